// File: rtl/thermo_pkg.sv
// thermo_pkg: shared state/mode encodings, setpoint defaults and setpoint stepping
package thermo_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, HEAT = 2'd1, COOL = 2'd2, HOLD = 2'd3} state_t;
    localparam logic [1:0] OFF       = 2'd0;
    localparam logic [1:0] HEAT_ONLY = 2'd1;
    localparam logic [1:0] COOL_ONLY = 2'd2;
    localparam logic [1:0] AUTO      = 2'd3;
    localparam int SET_INIT_DEF = 22;
    localparam int SET_MIN_DEF  = 10;
    localparam int SET_MAX_DEF  = 35;
    function automatic logic [7:0] sat_step(input logic [7:0] v, input logic up, input logic dn,
                                            input logic [7:0] lo, input logic [7:0] hi);
        return (up && !dn) ? ((v >= hi) ? hi : v + 8'd1) :
               (dn && !up) ? ((v <= lo) ? lo : v - 8'd1) : v;
    endfunction
endpackage

// File: rtl/thermo_avg4.sv
// thermo_avg4: 4-tap moving average of 8-bit samples; the first tick primes every tap
module thermo_avg4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    logic [3:0][7:0] tap_q, tap_d;
    logic            prime_q, prime_d;
    logic [7:0]      dout_q, dout_d;
    logic [9:0]      sum;
    always_comb begin
        tap_d   = !tick ? tap_q : prime_q ? {din, tap_q[3:1]} : {4{din}};
        prime_d = prime_q | tick;
        sum     = 10'(tap_d[0]) + 10'(tap_d[1]) + 10'(tap_d[2]) + 10'(tap_d[3]);
        dout_d  = tick ? sum[9:2] : dout_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q   <= '0;
            prime_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            tap_q   <= tap_d;
            prime_q <= prime_d;
            dout_q  <= dout_d;
        end
    end
    assign dout = dout_q;
endmodule

// File: rtl/thermostat_ctrl.sv
// thermostat_ctrl: hysteresis heat/cool decision with anti-short-cycle FSM.
// Define THERMO_AVG_EN to smooth samples with the 4-tap average; otherwise raw samples are used.
module thermostat_ctrl
    import thermo_pkg::*;
#(
    parameter int         SAMPLE_DIV = 1000,
    parameter logic [7:0] HYST       = 8'd1,
    parameter int         MIN_RUN    = 200,
    parameter int         MIN_OFF    = 200,
    parameter int         SET_INIT   = SET_INIT_DEF,
    parameter int         SET_MIN    = SET_MIN_DEF,
    parameter int         SET_MAX    = SET_MAX_DEF
) (
    input  logic       clk_200kHz,
    input  logic       reset,
    input  logic [7:0] temp_data,
    input  logic [1:0] mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] setpoint,
    output logic [7:0] temp_filt,
    output logic       heat_on,
    output logic       cool_on,
    output logic [1:0] ctrl_state
);
    localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic          up_q, up_d, dn_q, dn_d;
    logic [7:0]    sp_q, sp_d;
    logic [7:0]    filt;
    logic [8:0]    lo, hi, hi_sum;
    logic          heat_ok, cool_ok, keep_ok, run_done;
    state_t        state_q, state_d;
    logic [15:0]   run_q, run_d, off_q, off_d;
    logic          heat_q, heat_d, cool_q, cool_d;
`ifdef THERMO_AVG_EN
    thermo_avg4 u_avg (.clk(clk_200kHz), .rst(reset), .tick(tick), .din(temp_data), .dout(filt));
`else
    logic [7:0] filt_q, filt_d;
    always_comb filt_d = tick ? temp_data : filt_q;
    always_ff @(posedge clk_200kHz) filt_q <= reset ? '0 : filt_d;
    assign filt = filt_q;
`endif
    assign tick = div_q == DW'(SAMPLE_DIV - 1);
    always_comb begin
        div_d    = tick ? '0 : div_q + 1'b1;
        up_d     = btn_up;
        dn_d     = btn_down;
        sp_d     = sat_step(sp_q, btn_up & ~up_q, btn_down & ~dn_q, 8'(SET_MIN), 8'(SET_MAX));
        lo       = sp_q >= HYST ? {1'b0, sp_q - HYST} : 9'd0;
        hi_sum   = {1'b0, sp_q} + {1'b0, HYST};
        hi       = hi_sum[8] ? 9'd255 : hi_sum;
        heat_ok  = mode == HEAT_ONLY || mode == AUTO;
        cool_ok  = mode == COOL_ONLY || mode == AUTO;
        keep_ok  = state_q == HEAT ? heat_ok : cool_ok;
        run_done = tick && run_q >= 16'(MIN_RUN) && (state_q == HEAT ? filt >= sp_q : filt <= sp_q);
        state_d  = state_q;
        run_d    = run_q;
        off_d    = off_q;
        if (state_q == IDLE && tick && heat_ok && {1'b0, filt} <= lo) begin
            state_d = HEAT;
            run_d   = '0;
        end else if (state_q == IDLE && tick && cool_ok && {1'b0, filt} >= hi) begin
            state_d = COOL;
            run_d   = '0;
        end else if (state_q == HEAT || state_q == COOL) begin
            if (!keep_ok || run_done) begin
                state_d = HOLD;
                off_d   = '0;
            end else if (tick && run_q != '1) begin
                run_d = run_q + 1'b1;
            end
        end else if (state_q == HOLD && tick) begin
            if (off_q == 16'(MIN_OFF - 1)) state_d = IDLE;
            off_d = off_q + 1'b1;
        end
        heat_d = state_d == HEAT;
        cool_d = state_d == COOL;
    end
    always_ff @(posedge clk_200kHz) begin
        if (reset) begin
            div_q   <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            sp_q    <= 8'(SET_INIT);
            state_q <= IDLE;
            run_q   <= '0;
            off_q   <= '0;
            heat_q  <= 1'b0;
            cool_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            sp_q    <= sp_d;
            state_q <= state_d;
            run_q   <= run_d;
            off_q   <= off_d;
            heat_q  <= heat_d;
            cool_q  <= cool_d;
        end
    end
    assign setpoint   = sp_q;
    assign temp_filt  = filt;
    assign heat_on    = heat_q;
    assign cool_on    = cool_q;
    assign ctrl_state = state_q;
endmodule

// File: tb/tb_thermostat_ctrl.sv
// tb_thermostat_ctrl: directed vector table plus randomized run against a behavioural model
module tb_thermostat_ctrl;
    localparam int SD = 8;
    localparam int HY = 1;
    localparam int MR = 2;
    localparam int MO = 2;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] temp_data = '0;
    logic [1:0] mode = '0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [7:0] setpoint, temp_filt;
    logic       heat_on, cool_on;
    logic [1:0] ctrl_state;
    thermostat_ctrl #(.SAMPLE_DIV(SD), .HYST(8'(HY)), .MIN_RUN(MR), .MIN_OFF(MO)) dut (
        .clk_200kHz(clk), .reset(reset), .temp_data(temp_data), .mode(mode),
        .btn_up(btn_up), .btn_down(btn_down), .setpoint(setpoint), .temp_filt(temp_filt),
        .heat_on(heat_on), .cool_on(cool_on), .ctrl_state(ctrl_state)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // Behavioural model: states 0 idle, 1 heating, 2 cooling, 3 hold; counts in plain ints
    int m_cnt, m_sp, m_filt, m_st, m_run, m_off, lo, hi;
    int hist[$];
    bit m_pu, m_pd, tk, hok, cok, up, dn, model_on = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_sp = 22; m_filt = 0; m_st = 0; m_run = 0; m_off = 0;
            m_pu = 0; m_pd = 0; hist.delete();
        end else begin
            tk  = (m_cnt % SD) == SD - 1;
            m_cnt++;
            lo  = (m_sp - HY < 0) ? 0 : m_sp - HY;
            hi  = (m_sp + HY > 255) ? 255 : m_sp + HY;
            hok = mode == 2'd1 || mode == 2'd3;
            cok = mode == 2'd2 || mode == 2'd3;
            if (m_st == 0) begin
                if (tk && hok && m_filt <= lo) begin m_st = 1; m_run = 0; end
                else if (tk && cok && m_filt >= hi) begin m_st = 2; m_run = 0; end
            end else if (m_st == 3) begin
                if (tk) begin
                    if (m_off == MO - 1) m_st = 0;
                    else m_off++;
                end
            end else if (!(m_st == 1 ? hok : cok) ||
                         (tk && m_run >= MR && (m_st == 1 ? m_filt >= m_sp : m_filt <= m_sp))) begin
                m_st = 3; m_off = 0;
            end else if (tk && m_run < 65535) begin
                m_run++;
            end
            if (tk) begin
`ifdef THERMO_AVG_EN
                if (hist.size() == 0) repeat (4) hist.push_back(int'(temp_data));
                else begin hist.push_back(int'(temp_data)); void'(hist.pop_front()); end
                m_filt = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
                m_filt = temp_data;
`endif
            end
            up = btn_up && !m_pu;
            dn = btn_down && !m_pd;
            m_pu = btn_up;
            m_pd = btn_down;
            if (up && !dn) m_sp = (m_sp + 1 > 35) ? 35 : m_sp + 1;
            if (dn && !up) m_sp = (m_sp - 1 < 10) ? 10 : m_sp - 1;
        end
    end
    always @(negedge clk) if (model_on) begin
        check("model_setpoint", setpoint, m_sp);
        check("model_temp_filt", temp_filt, m_filt);
        check("model_state", ctrl_state, m_st);
        check("model_heat_on", heat_on, int'(m_st == 1));
        check("model_cool_on", cool_on, int'(m_st == 2));
    end
    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] temp;
        logic [1:0] st_r;
        logic [7:0] f_r;
        logic [1:0] st_a;
        logic [7:0] f_a;
    } vec_t;
    vec_t tbl [17];
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic press(input logic u, input logic d);
        btn_up = u; btn_down = d;
        @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        int est, ef;
        tbl[0]  = '{2'd1, 8'd18, 2'd1, 8'd18, 2'd1, 8'd18};
        tbl[1]  = '{2'd1, 8'd22, 2'd1, 8'd22, 2'd1, 8'd19};
        tbl[2]  = '{2'd1, 8'd22, 2'd1, 8'd22, 2'd1, 8'd20};
        tbl[3]  = '{2'd1, 8'd22, 2'd3, 8'd22, 2'd1, 8'd21};
        tbl[4]  = '{2'd1, 8'd22, 2'd3, 8'd22, 2'd1, 8'd22};
        tbl[5]  = '{2'd1, 8'd22, 2'd0, 8'd22, 2'd3, 8'd22};
        tbl[6]  = '{2'd1, 8'd22, 2'd0, 8'd22, 2'd3, 8'd22};
        tbl[7]  = '{2'd1, 8'd22, 2'd0, 8'd22, 2'd0, 8'd22};
        tbl[8]  = '{2'd3, 8'd30, 2'd0, 8'd30, 2'd0, 8'd24};
        tbl[9]  = '{2'd3, 8'd30, 2'd2, 8'd30, 2'd2, 8'd26};
        tbl[10] = '{2'd3, 8'd30, 2'd2, 8'd30, 2'd2, 8'd28};
        tbl[11] = '{2'd3, 8'd30, 2'd2, 8'd30, 2'd2, 8'd30};
        tbl[12] = '{2'd3, 8'd22, 2'd2, 8'd22, 2'd2, 8'd28};
        tbl[13] = '{2'd3, 8'd22, 2'd3, 8'd22, 2'd2, 8'd26};
        tbl[14] = '{2'd3, 8'd22, 2'd3, 8'd22, 2'd2, 8'd24};
        tbl[15] = '{2'd3, 8'd22, 2'd0, 8'd22, 2'd2, 8'd22};
        tbl[16] = '{2'd3, 8'd22, 2'd0, 8'd22, 2'd3, 8'd22};
        @(negedge clk);
        reset = 1'b0;
        model_on = 1'b1;
        check("reset_setpoint", setpoint, 22);
        check("reset_temp_filt", temp_filt, 0);
        check("reset_heat_on", heat_on, 0);
        check("reset_cool_on", cool_on, 0);
        check("reset_state", ctrl_state, 0);
        for (int i = 0; i < 17; i++) begin
            mode = tbl[i].mode;
            temp_data = tbl[i].temp;
            repeat (SD) @(negedge clk);
`ifdef THERMO_AVG_EN
            est = tbl[i].st_a; ef = tbl[i].f_a;
`else
            est = tbl[i].st_r; ef = tbl[i].f_r;
`endif
            check($sformatf("vec%0d_state", i), ctrl_state, est);
            check($sformatf("vec%0d_filt", i), temp_filt, ef);
            check($sformatf("vec%0d_heat", i), heat_on, int'(est == 1));
            check($sformatf("vec%0d_cool", i), cool_on, int'(est == 2));
        end
        do_reset();
        mode = 2'd1; temp_data = 8'd18;
        repeat (SD) @(negedge clk);
        check("drop_in_heat", ctrl_state, 1);
        repeat (3) @(negedge clk);
        mode = 2'd0;
        @(negedge clk);
        check("drop_state_hold", ctrl_state, 3);
        check("drop_heat_off", heat_on, 0);
        do_reset();
        mode = 2'd1;
        repeat (SD) @(negedge clk);
        check("rst_in_heat", heat_on, 1);
        btn_up = 1'b1;
        @(negedge clk);
        check("sp_next_cycle", setpoint, 23);
        btn_up = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_heat_off", heat_on, 0);
        check("rst_state_idle", ctrl_state, 0);
        check("rst_setpoint", setpoint, 22);
        check("rst_temp_filt", temp_filt, 0);
        reset = 1'b0;
        mode = 2'd0;
        repeat (20) press(1'b1, 1'b0);
        check("sp_sat_max", setpoint, 35);
        press(1'b1, 1'b1);
        check("sp_both_max", setpoint, 35);
        repeat (30) press(1'b0, 1'b1);
        check("sp_sat_min", setpoint, 10);
        press(1'b1, 1'b1);
        check("sp_both_min", setpoint, 10);
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(63) == 0) mode = 2'($urandom_range(3));
            temp_data = 8'(14 + $urandom_range(19));
            if ($urandom_range(5) == 0) btn_up = ~btn_up;
            if ($urandom_range(5) == 0) btn_down = ~btn_down;
            reset = $urandom_range(699) == 0;
            @(negedge clk);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
